// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, keeps one instruction-memory read in
// flight and buffers returned words in a 2-entry queue whose head feeds the decoder.
module fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instru,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              stall,
  input  logic              BrTaken,
  input  logic              UncondBr
);

  function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] pc,
                                                      input logic [31:0]       ins,
                                                      input logic              uncond);
    logic signed [ADDR_W-1:0] off;
    if (uncond) off = {{(ADDR_W-26){ins[25]}}, ins[25:0]};
    else        off = {{(ADDR_W-19){ins[23]}}, ins[23:5]};
    return pc + $unsigned(off <<< 2);
  endfunction

  logic [1:0]        occ, occ_n;
  logic              discard, discard_n;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
  logic              req_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       q_word [2];
  logic [ADDR_W-1:0] q_pc   [2];

  logic ack_eff, consume, redirect, still_out, push, wr_idx;

  assign instr_valid = (occ != 2'd0);
  assign instru      = instr_valid ? q_word[0] : '0;
  assign instr_pc    = instr_valid ? q_pc[0]   : '0;

  always_comb begin
    ack_eff    = imem_req & imem_ack;
    consume    = instr_valid & ~stall;
    redirect   = consume & BrTaken;
    still_out  = imem_req & ~imem_ack;
    // A word acked on a redirect cycle is wrong-path as well, so it is never pushed.
    push       = ack_eff & ~discard & ~redirect;
    wr_idx     = (occ == 2'd2) | ((occ == 2'd1) & ~consume);

    occ_n      = occ - {1'b0, consume} + {1'b0, push};
    fetch_pc_n = fetch_pc;
    discard_n  = discard;
    if (push) fetch_pc_n = imem_addr + ADDR_W'(4);
    if (ack_eff) discard_n = 1'b0;
    if (redirect) begin
      occ_n      = 2'd0;
      fetch_pc_n = branch_target(q_pc[0], q_word[0], UncondBr);
      if (still_out) discard_n = 1'b1;
    end

    // An outstanding read is held untouched; otherwise issue whenever the queue has room.
    req_n  = still_out | (occ_n != 2'd2);
    addr_n = still_out ? imem_addr : fetch_pc_n;
  end

  // ---- control state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      occ       <= 2'd0;
      discard   <= 1'b0;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      occ       <= occ_n;
      discard   <= discard_n;
      fetch_pc  <= fetch_pc_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
    end
  end

  // ---- queue storage ----
  always_ff @(posedge clk) begin
    if (consume) begin
      q_word[0] <= q_word[1];
      q_pc[0]   <= q_pc[1];
    end
    if (push) begin
      q_word[wr_idx] <= imem_rdata;
      q_pc[wr_idx]   <= imem_addr;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder and decoder stand-in drive the DUT; an
// architectural PC model fills a scoreboard that a separate monitor drains on each consume.
module tb_fetch_unit;
  localparam int          ADDR_W   = 64;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_ack, instr_valid, stall, BrTaken, UncondBr;
  logic [63:0] imem_addr, instr_pc;
  logic [31:0] imem_rdata, instru;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instru(instru), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .stall(stall), .BrTaken(BrTaken), .UncondBr(UncondBr)
  );

  typedef struct packed { logic [63:0] pc; logic [31:0] w; } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0, pops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Program image: a few fixed branch words, a hash everywhere else.
  function automatic logic [31:0] imem_word(input logic [63:0] a);
    case (a)
      64'h10:  return 32'h14000003;  // B +3
      64'h20:  return 32'h14000038;  // B to 0x100
      64'h40:  return 32'hB4FFFFC0;  // CBZ, imm19 = -2
      default: return a[33:2] * 32'h9E3779B1 + 32'h7F4A7C15;
    endcase
  endfunction

  function automatic logic [63:0] tgt(input logic [63:0] pc, input logic [31:0] w, input logic unc);
    longint off;
    if (unc) off = longint'($signed(w[25:0]));
    else     off = longint'($signed(w[23:5]));
    return pc + 64'(off * 4);
  endfunction

  // stimulus-side state
  int          lat = 0, cnt = 0, fixed_lat = 0, stall_cnt = 0, watch = 0;
  bit          rnd_lat = 0, rnd_mode = 0, prev_ack = 0, prev_req = 0;
  bit          st8 = 0, b10 = 0, b40 = 0, b20 = 0, chk38 = 0;
  logic [63:0] model_pc;
  logic [31:0] held;

  task automatic step(input bit rst_v, input bit stray);
    exp_t e;
    @(negedge clk);
    reset = rst_v;
    if (!rst_v && chk38) begin
      chk38 = 0;
      check("cbz_req", imem_req, 1);
      check("cbz_addr", imem_addr, 64'h38);
    end
    if (!rst_v && watch > 0) begin
      if (imem_req && imem_addr != 64'h24) begin
        check("redirect_addr", imem_addr, 64'h100);
        watch = 0;
      end else begin
        watch--;
        if (watch == 0) fail_now("redirect_addr");
      end
    end
    // memory responder: ack once a request has waited lat cycles
    if (rst_v || prev_ack) begin
      cnt = 0;
      lat = rnd_lat ? int'($urandom_range(0, 3)) : fixed_lat;
    end else if (imem_req && prev_req) cnt++;
    else cnt = 0;
    imem_ack   = !rst_v && imem_req && (cnt >= lat);
    imem_rdata = imem_ack ? imem_word(imem_addr) : $urandom();
    if (stray) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEADBEEF;
    end
    prev_ack = imem_ack && imem_req && !rst_v;
    prev_req = imem_req && !rst_v;
    if (rst_v) begin
      stall = 0; BrTaken = 0; UncondBr = 0;
      sb.delete();
      model_pc = RESET_PC;
      e.pc = RESET_PC; e.w = imem_word(RESET_PC);
      sb.push_back(e);
      return;
    end
    // decoder stand-in
    if (rnd_mode) begin
      stall    = ($urandom_range(0, 9) < 3);
      BrTaken  = ($urandom_range(0, 4) == 0);
      UncondBr = 1'($urandom_range(0, 1));
    end else begin
      if (stall_cnt > 0) begin
        stall = 1;
        if (stall_cnt == 1) begin
          check("stall_req_low", imem_req, 0);
          check("stall_instru_stable", instru, held);
          check("stall_pc_stable", instr_pc, 64'h8);
        end
        stall_cnt--;
      end else if (st8 && instr_valid && instr_pc == 64'h8) begin
        st8 = 0; stall = 1; held = instru; stall_cnt = 5;
      end else stall = 0;
      BrTaken  = 1'($urandom_range(0, 1));
      UncondBr = 1'($urandom_range(0, 1));
      if (instr_valid && !stall) begin
        BrTaken = 0;
        if (b10 && instr_pc == 64'h10) begin b10 = 0; BrTaken = 1; UncondBr = 1; end
        if (b40 && instr_pc == 64'h40) begin b40 = 0; BrTaken = 1; UncondBr = 0; chk38 = 1; end
        if (b20 && instr_pc == 64'h20) begin b20 = 0; BrTaken = 1; UncondBr = 1; watch = 30; end
      end
    end
    // architectural model: next instruction after the one consumed this cycle
    if (instr_valid && !stall) begin
      model_pc = BrTaken ? tgt(model_pc, imem_word(model_pc), UncondBr) : model_pc + 64'd4;
      e.pc = model_pc; e.w = imem_word(model_pc);
      sb.push_back(e);
    end
  endtask

  task automatic reset_seq(input bit stray);
    step(1, 0);
    step(1, 0);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_instru", instru, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_valid", instr_valid, 0);
    step(0, stray);
    step(0, 0);
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, RESET_PC);
  endtask

  // monitor: protocol checks every cycle, scoreboard pop on every consume
  bit          mon_hold = 0;
  logic [63:0] mon_addr;
  always @(negedge clk) begin
    #2;
    if (reset) mon_hold = 0;
    else begin
      if (imem_req) check("addr_align", imem_addr[1:0], 0);
      if (mon_hold) begin
        check("req_held", imem_req, 1);
        check("addr_held", imem_addr, mon_addr);
      end
      if (instr_valid && !stall) begin
        if (sb.size() == 0) fail_now("sb_empty");
        else begin
          exp_t e;
          e = sb.pop_front();
          pops++;
          check("instr_pc", instr_pc, e.pc);
          check("instru", instru, e.w);
        end
      end
      mon_hold = imem_req && !imem_ack;
      mon_addr = imem_addr;
    end
  end

  initial begin
    int p0;
    bit found;
    reset = 1; stall = 0; BrTaken = 0; UncondBr = 0; imem_ack = 0; imem_rdata = 0;

    // zero-wait streaming
    reset_seq(0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0);
      check("stream_valid", instr_valid, 1);
      check("stream_pc", instr_pc, 64'(4 * i));
    end
    repeat (16) step(0, 0);

    // stall at 0x8, B at 0x10, CBZ at 0x40
    st8 = 1; b10 = 1; b40 = 1;
    reset_seq(0);
    repeat (70) step(0, 0);
    check("directed_fired", {st8, b10, b40}, 0);

    // latency 3, redirect while the next read is in flight
    fixed_lat = 3; b20 = 1;
    reset_seq(0);
    repeat (90) step(0, 0);
    check("lat_branch_fired", b20, 0);

    // reset while a read is pending, then a stray late ack
    reset_seq(0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0);
      if (imem_req && !imem_ack) found = 1;
    end
    if (!found) fail_now("pending_req");
    reset_seq(1);
    repeat (30) step(0, 0);

    // randomized traffic
    rnd_mode = 1; rnd_lat = 1;
    reset_seq(0);
    p0 = pops;
    repeat (800) step(0, 0);
    checks++;
    if (pops - p0 < 60) begin
      failures++;
      $display("FAIL random_progress actual=%0d required>=60", pops - p0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
